updown_counter_mod: RTL and testbench
=====================================

Name: updown_counter_mod

Overview:
- Synchronous up/down modulo-N counter: the consumer stage of the team's D flip-flop.
- Holds one stored state bit per counter bit and computes the next-state logic that drives those storage elements.
- Default configuration is the 4-bit binary counter; it can also be configured as a decade counter (MODULUS=10).
- Supplies count value, terminal-count and overflow/underflow indication to downstream display/cascade logic.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 16, number of states; count range 0..MODULUS-1. Legal range 2..2**WIDTH. Elaboration error outside this range.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset; assertion clears all state immediately, deassertion is synchronous to clk.
- en  input  1  count enable; one step per clock while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load; overrides en.
- load_val  input  WIDTH  value captured on load.
- count  output  WIDTH  registered counter value.
- tc  output  1  combinational terminal count: en & ((up_dn & count==MODULUS-1) | (~up_dn & count==0)).
- wrap  output  1  registered one-cycle pulse; high in the cycle after the counter wrapped (either direction).

Behaviour:
- Reset (reset_n=0, any time, including mid-count or mid-load):
  - count=0 and wrap=0 immediately, independent of clk.
  - tc follows its equation.
  - The first count update occurs on the first rising clk edge with reset_n=1.
- Priority per rising edge: load > en > hold.
- Load:
  - count <= load_val if load_val <= MODULUS-1, else count <= MODULUS-1 (clamp).
  - wrap <= 0.
  - en and up_dn are ignored that cycle.
- Count up (en=1, up_dn=1, load=0):
  - count==MODULUS-1 -> count <= 0, wrap <= 1.
  - Otherwise count <= count+1, wrap <= 0.
- Count down (en=1, up_dn=0, load=0):
  - count==0 -> count <= MODULUS-1, wrap <= 1.
  - Otherwise count <= count-1, wrap <= 0.
- Hold (en=0, load=0): count unchanged, wrap <= 0.
- Latency:
  - count reflects a step or load one clock after the sampling edge.
  - wrap is aligned with the first cycle of the wrapped count value.
- Direction change: up_dn may toggle on any cycle; it takes effect on the same edge it is sampled. No dead cycle.
- Cascading: tc of stage k drives en of stage k+1. tc is combinational from en, count and up_dn only; no path from load.
- Arithmetic: next-state computed at WIDTH+1 bits, then compared against MODULUS-1. No reliance on natural 2**WIDTH rollover when MODULUS < 2**WIDTH.
- Unreachable count values (count >= MODULUS, only possible after an SEU):
  - Next enabled up-step -> 0 with wrap <= 1.
  - Next enabled down-step -> MODULUS-1 with wrap <= 0.

Optional Feature:
- Macro UPDOWN_COUNTER_SATURATE_EN.
- Defined:
  - Counter saturates: up at MODULUS-1 holds MODULUS-1; down at 0 holds 0.
  - wrap is repurposed as a one-cycle saturation-attempt pulse, high in the cycle after an enabled step was blocked at a bound.
  - tc is unchanged.
- Undefined: wrap-around behaviour as specified above.

Test Plan:
- Reset/hold: reset_n=0 with count=7 mid-operation -> count=0 and wrap=0 before the next clk edge. Release, en=0 for 5 cycles -> count stays 0.
- Binary up wrap (WIDTH=4, MODULUS=16): en=1, up_dn=1 for 17 cycles from 0 -> count 0..15,0,1. tc=1 only while count=15. wrap=1 only in the cycle count=0 after 15.
- Decade down wrap (MODULUS=10): load_val=2 then en=1, up_dn=0 -> count 2,1,0,9,8. wrap=1 in the count=9 cycle. tc=1 while count=0.
- Load priority/clamp (MODULUS=10): load=1, en=1, load_val=13 -> count=9, wrap=0. Next cycle load=0, up -> count=0, wrap=1.
- Direction toggle: count=5, en=1, up_dn sequence 1,1,0,0,1 -> count 6,7,6,5,6. wrap never asserts.
- UPDOWN_COUNTER_SATURATE_EN (MODULUS=16): count=15, en=1, up_dn=1 for 3 cycles -> count stays 15, wrap=1 each following cycle. Then up_dn=0 -> 14, wrap=0.

Source files
------------

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: synchronous up/down modulo-N counter.
//   Default build wraps at the bounds (0 <-> MODULUS-1) with a one-cycle wrap pulse.
//   Define UPDOWN_COUNTER_SATURATE_EN to make it saturate at the bounds instead;
//   wrap then pulses when an enabled step was blocked at a bound.
//   tc is combinational from en/up_dn/count so stages can be cascaded tc -> en.
module updown_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Reject modulus values the count register cannot represent
    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("updown_counter_mod: MODULUS must be in 2..2**WIDTH");
        end
    endgenerate

    // All next-state arithmetic is one bit wider so MODULUS == 2**WIDTH still
    // compares correctly and nothing relies on natural rollover.
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] ld_ext;
    logic [WIDTH:0] inc_ext;
    logic [WIDTH:0] dec_ext;
    logic [WIDTH:0] nxt_ext;
    logic           nxt_wrap;
    logic           at_max;
    logic           at_zero;
    logic           over_max;
    logic           unused_nxt_top;

    assign cnt_ext  = {1'b0, count};
    assign ld_ext   = {1'b0, load_val};
    assign inc_ext  = cnt_ext + (WIDTH+1)'(1);
    assign dec_ext  = cnt_ext - (WIDTH+1)'(1);
    assign at_max   = (cnt_ext == MAX_EXT);
    assign at_zero  = (cnt_ext == '0);
    // Only reachable through an upset; steered back into range on the next step
    assign over_max = (cnt_ext > MAX_EXT);

    // Terminal count: no dependence on load so cascades stay glitch-free on loads
    assign tc = en & ((up_dn & at_max) | (~up_dn & at_zero));

    // Next-state selection: load beats enable beats hold
    always_comb begin
        nxt_ext  = cnt_ext;
        nxt_wrap = 1'b0;
        if (load) begin
            nxt_ext = (ld_ext > MAX_EXT) ? MAX_EXT : ld_ext;
        end else if (en) begin
            if (up_dn) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                if (at_max) begin
                    nxt_wrap = 1'b1;
                end else if (over_max) begin
                    nxt_ext = MAX_EXT;
                end else begin
                    nxt_ext = inc_ext;
                end
`else
                if (at_max || over_max) begin
                    nxt_ext  = '0;
                    nxt_wrap = 1'b1;
                end else begin
                    nxt_ext = inc_ext;
                end
`endif
            end else begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
                if (at_zero) begin
                    nxt_wrap = 1'b1;
                end else if (over_max) begin
                    nxt_ext = MAX_EXT;
                end else begin
                    nxt_ext = dec_ext;
                end
`else
                if (at_zero) begin
                    nxt_ext  = MAX_EXT;
                    nxt_wrap = 1'b1;
                end else if (over_max) begin
                    nxt_ext = MAX_EXT;
                end else begin
                    nxt_ext = dec_ext;
                end
`endif
            end
        end
    end

    // Next value never exceeds MAX_EXT, so the extra top bit is always zero
    assign unused_nxt_top = nxt_ext[WIDTH];

    // State registers; reset clears count and wrap immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= nxt_ext[WIDTH-1:0];
            wrap  <= nxt_wrap;
        end
    end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench: one binary (MODULUS=16) and one decade (MODULUS=10) counter
// share inputs; each directed step names which instance it checks.
module tb_updown_counter_mod;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] cnt_b, cnt_d;
    logic       tc_b, tc_d, wrap_b, wrap_d;

    int checks = 0;
    int errors = 0;
    int step   = 0;

    typedef struct {
        bit         sel;   // 0 = binary, 1 = decade
        logic [3:0] cnt;
        logic       wrap;
        logic       tc;
        int         id;
    } exp_t;

    exp_t q[$];

    updown_counter_mod #(.WIDTH(4), .MODULUS(16)) u_bin (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(cnt_b), .tc(tc_b), .wrap(wrap_b)
    );

    updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_dec (
        .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(cnt_d), .tc(tc_d), .wrap(wrap_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge
    task automatic cyc(input bit sel, input bit ld, input logic [3:0] lv, input bit e,
                       input bit ud, input logic [3:0] xc, input bit xw, input bit xt);
        exp_t x;
        @(negedge clk);
        load = ld; load_val = lv; en = e; up_dn = ud;
        x.sel = sel; x.cnt = xc; x.wrap = xw; x.tc = xt; x.id = step;
        q.push_back(x);
        step++;
    endtask

    // Monitor: after every rising edge, compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.sel) begin
                    chk($sformatf("dec_step%0d_count", e.id), {4'd0, cnt_d},  {4'd0, e.cnt});
                    chk($sformatf("dec_step%0d_wrap",  e.id), {7'd0, wrap_d}, {7'd0, e.wrap});
                    chk($sformatf("dec_step%0d_tc",    e.id), {7'd0, tc_d},   {7'd0, e.tc});
                end else begin
                    chk($sformatf("bin_step%0d_count", e.id), {4'd0, cnt_b},  {4'd0, e.cnt});
                    chk($sformatf("bin_step%0d_wrap",  e.id), {7'd0, wrap_b}, {7'd0, e.wrap});
                    chk($sformatf("bin_step%0d_tc",    e.id), {7'd0, tc_b},   {7'd0, e.tc});
                end
            end
        end
    end

    initial begin
        int k;
        reset_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        #3;
        chk("rst_bin_count", {4'd0, cnt_b}, 8'd0);
        chk("rst_bin_wrap",  {7'd0, wrap_b}, 8'd0);
        chk("rst_bin_tc",    {7'd0, tc_b},   8'd0);
        chk("rst_dec_count", {4'd0, cnt_d}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Asynchronous reset mid-operation from count=7
        cyc(0, 1, 4'd7, 0, 1, 4'd7, 0, 0);
        @(negedge clk);
        load = 1'b0; en = 1'b1; up_dn = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_count", {4'd0, cnt_b}, 8'd0);
        chk("async_rst_wrap",  {7'd0, wrap_b}, 8'd0);
        chk("async_rst_tc_down_at_zero", {7'd0, tc_b}, 8'd1);
        @(posedge clk);
        #1;
        chk("rst_held_over_edge", {4'd0, cnt_b}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1; en = 1'b0; up_dn = 1'b1;
        for (int i = 0; i < 5; i++) cyc(0, 0, 4'd0, 0, 1, 4'd0, 0, 0);

        // Binary up wrap: 17 steps from 0
        for (int i = 1; i <= 17; i++) begin
            k = i % 16;
            cyc(0, 0, 4'd0, 1, 1, 4'(k), (i == 16), (k == 15));
        end

        // Decade down wrap from 2
        cyc(1, 1, 4'd2, 0, 0, 4'd2, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd1, 0, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd0, 0, 1);
        cyc(1, 0, 4'd0, 1, 0, 4'd9, 1, 0);
        cyc(1, 0, 4'd0, 1, 0, 4'd8, 0, 0);
        cyc(1, 0, 4'd0, 0, 0, 4'd8, 0, 0);

        // Decade load priority and clamp
        cyc(1, 1, 4'd13, 1, 1, 4'd9, 0, 1);
        cyc(1, 0, 4'd0,  1, 1, 4'd0, 1, 0);
        cyc(1, 1, 4'd10, 0, 1, 4'd9, 0, 0);
        cyc(1, 1, 4'd9,  1, 0, 4'd9, 0, 0);
        cyc(1, 0, 4'd0,  1, 0, 4'd8, 0, 0);

        // Binary direction toggles from 5
        cyc(0, 1, 4'd5, 0, 1, 4'd5, 0, 0);
        cyc(0, 0, 4'd0, 1, 1, 4'd6, 0, 0);
        cyc(0, 0, 4'd0, 1, 1, 4'd7, 0, 0);
        cyc(0, 0, 4'd0, 1, 0, 4'd6, 0, 0);
        cyc(0, 0, 4'd0, 1, 0, 4'd5, 0, 0);
        cyc(0, 0, 4'd0, 1, 1, 4'd6, 0, 0);

        // Binary down wrap at 0, back up across the top, hold clears wrap
        cyc(0, 1, 4'd0, 0, 0, 4'd0,  0, 0);
        cyc(0, 0, 4'd0, 1, 0, 4'd15, 1, 0);
        cyc(0, 0, 4'd0, 1, 1, 4'd0,  1, 0);
        cyc(0, 0, 4'd0, 0, 1, 4'd0,  0, 0);
        // Load at the top with en high: no wrap, tc follows en/count
        cyc(0, 1, 4'd15, 1, 1, 4'd15, 0, 1);

        @(negedge clk);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
